// File: rtl/tree_cmd_frontend.sv
// tree_cmd_frontend: command front end for the Tree search-tree block.
// Synchronises and debounces the raw k0/k1 buttons and the sw switches, then
// converts each debounced press into exactly one FIND/INSERT/CLEAR command
// on a valid/ready handshake. A FIND on an empty tree or an INSERT on a full
// tree is rejected with a one-cycle cmd_err pulse and no command is issued.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   k0         raw FIND button (active-high, asynchronous)
//   k1         raw INSERT/CLEAR button (active-high, asynchronous)
//   sw[3:0]    raw switch value used as the key operand (asynchronous)
//   buf_empty  tree holds no keys
//   buf_full   tree holds the maximum number of keys
//   cmd_ready  tree accepts a command this cycle
//   cmd_valid  command present
//   cmd_op     00 FIND, 01 INSERT, 10 CLEAR
//   cmd_data   key captured at the press
//   cmd_err    one-cycle pulse: press rejected
//   busy       state machine is not idle
module tree_cmd_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       k0,
  input  logic       k1,
  input  logic [3:0] sw,
  input  logic       buf_empty,
  input  logic       buf_full,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_op,
  output logic [3:0] cmd_data,
  output logic       cmd_err,
  output logic       busy
);

  localparam int unsigned KEY_N = 2;
  localparam int unsigned SW_W  = 4;
  localparam int unsigned OP_W  = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [OP_W-1:0] OP_FIND   = 2'b00;
  localparam logic [OP_W-1:0] OP_INSERT = 2'b01;
  localparam logic [OP_W-1:0] OP_CLEAR  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_N-1:0] k_meta, k_sync;
  logic [SW_W-1:0]  sw_meta, sw_sync;
  logic [KEY_N-1:0] key_stable, key_stable_d, press_q;

  logic [1:0]       state, state_next;
  logic             valid_next, err_next;
  logic [OP_W-1:0]  op_next;
  logic [SW_W-1:0]  data_next;

  // Two-flop synchronisers for the buttons and switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_meta  <= '0;
      k_sync  <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      k_meta  <= {k1, k0};
      k_sync  <= k_meta;
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Per-key debounce: the stable value follows the synced input only after
  // it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  for (genvar g = 0; g < KEY_N; g++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             stable;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (k_sync[g] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= k_sync[g];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign key_stable[g] = stable;
  end

  // One-cycle press pulse on each 0->1 of a stable key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_stable_d <= '0;
      press_q      <= '0;
    end else begin
      key_stable_d <= key_stable;
      press_q      <= key_stable & ~key_stable_d;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_data  <= '0;
      cmd_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_valid <= valid_next;
      cmd_op    <= op_next;
      cmd_data  <= data_next;
      cmd_err   <= err_next;
      busy      <= (state_next != ST_IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    logic [OP_W-1:0] op_dec;
    logic            reject;

    state_next = state;
    valid_next = cmd_valid;
    op_next    = cmd_op;
    data_next  = cmd_data;
    err_next   = 1'b0;
    op_dec     = OP_FIND;
    reject     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|press_q) begin
          // k0 takes priority; a simultaneous k1 press is dropped
          if (press_q[0])            op_dec = OP_FIND;
          else if (sw_sync == '0)    op_dec = OP_CLEAR;
          else                       op_dec = OP_INSERT;

          reject = ((op_dec == OP_FIND)   && buf_empty) ||
                   ((op_dec == OP_INSERT) && buf_full);

          op_next   = op_dec;
          data_next = sw_sync;
          if (reject) begin
            err_next   = 1'b1;
            state_next = ST_RELEASE;
          end else begin
            valid_next = 1'b1;
            state_next = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          valid_next = 1'b0;
          state_next = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (key_stable == '0) state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule
